// File: rtl/i2c_read_nbytes_c_if.sv
// Bus and handshake signals between the config sequencer/I2C lines and the N-byte read master.
interface i2c_read_nbytes_c_if #(
  parameter int unsigned MAX_BYTES = 2
);
  localparam int unsigned DW = 8 * MAX_BYTES;

  logic          GO;
  logic [7:0]    SLAVE_ADDRESS;
  logic [2:0]    NBYTES;
  logic          SDAI;
  logic          SDAO;
  logic          SCLO;
  logic          END_OK;
  logic          ACK_OK;
  logic [DW-1:0] DATA;
  logic          DATA_VALID;
  logic [7:0]    ST;
  logic [7:0]    CNT;
  logic [7:0]    BYTE;

  modport master (
    input  GO, SLAVE_ADDRESS, NBYTES, SDAI,
    output SDAO, SCLO, END_OK, ACK_OK, DATA, DATA_VALID, ST, CNT, BYTE
  );

  modport slave (
    output GO, SLAVE_ADDRESS, NBYTES, SDAI,
    input  SDAO, SCLO, END_OK, ACK_OK, DATA, DATA_VALID, ST, CNT, BYTE
  );
endinterface

// File: rtl/i2c_read_nbytes_c.sv
// Bit-banged I2C read master on the PT_CK tick: START, address (read), 0..MAX_BYTES data bytes, STOP.
// Optional address-NACK retry/polling enabled by defining I2C_RD_ACK_RETRY_EN.
module i2c_read_nbytes_c #(
  parameter int unsigned MAX_BYTES = 2,
  parameter int unsigned RETRY_MAX = 8
) (
  input  logic                PT_CK,
  input  logic                RESET_N,
  i2c_read_nbytes_c_if.master bus
);
  localparam int unsigned DW = 8 * MAX_BYTES;
  localparam int unsigned AW = (RETRY_MAX > 1) ? $clog2(RETRY_MAX + 1) : 1;
`ifdef I2C_RD_ACK_RETRY_EN
  localparam int unsigned ATTEMPTS = RETRY_MAX;
`else
  localparam int unsigned ATTEMPTS = 1;
`endif
  localparam logic [AW-1:0] LAST_ATTEMPT = AW'(ATTEMPTS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_ADDR   = 3'd2,
    S_RDBYTE = 3'd3,
    S_STOP   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t        r_state;
  logic [1:0]    r_ph;
  logic [3:0]    r_bit;
  logic [2:0]    r_byte;
  logic [2:0]    r_nbytes;
  logic [6:0]    r_addr;
  logic [7:0]    r_shift;
  logic [AW-1:0] r_attempt;
  logic          r_complete;
  logic          r_sdao;
  logic          r_sclo;
  logic          r_end_ok;
  logic          r_ack_ok;
  logic          r_dv;
  logic [DW-1:0] r_data;

  logic [8:0] w_addr_frame;
  logic [2:0] w_nbytes_clamped;
  logic       w_last;

  // Address frame: 7-bit address, R/W forced to read, then SDA released for the slave ACK.
  assign w_addr_frame     = {r_addr, 1'b1, 1'b1};
  assign w_nbytes_clamped = (32'(bus.NBYTES) > MAX_BYTES) ? 3'(MAX_BYTES) : bus.NBYTES;
  assign w_last           = (r_byte == 3'(r_nbytes - 3'd1));

  always_ff @(posedge PT_CK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= S_IDLE;
      r_ph       <= 2'd0;
      r_bit      <= 4'd0;
      r_byte     <= 3'd0;
      r_nbytes   <= 3'd0;
      r_addr     <= 7'd0;
      r_shift    <= 8'd0;
      r_attempt  <= '0;
      r_complete <= 1'b0;
      r_sdao     <= 1'b1;
      r_sclo     <= 1'b1;
      r_end_ok   <= 1'b1;
      r_ack_ok   <= 1'b0;
      r_dv       <= 1'b0;
      r_data     <= '0;
    end else begin
      r_dv <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_sdao   <= 1'b1;
          r_sclo   <= 1'b1;
          r_end_ok <= 1'b1;
          if (bus.GO) begin
            r_nbytes   <= w_nbytes_clamped;
            r_addr     <= bus.SLAVE_ADDRESS[7:1];
            r_attempt  <= '0;
            r_complete <= 1'b0;
            r_end_ok   <= 1'b0;
            r_ph       <= 2'd0;
            r_state    <= S_START;
          end
        end

        // SDA falls while SCL is high, then SCL is pulled low.
        S_START: begin
          r_ph <= r_ph + 2'd1;
          if (r_ph == 2'd0) begin
            r_sdao <= 1'b0;
          end else if (r_ph == 2'd2) begin
            r_sclo  <= 1'b0;
            r_ph    <= 2'd0;
            r_bit   <= 4'd0;
            r_byte  <= 3'd0;
            r_state <= S_ADDR;
          end
        end

        S_ADDR: begin
          r_ph <= r_ph + 2'd1;
          unique case (r_ph)
            2'd0: r_sdao <= w_addr_frame[4'(4'd8 - r_bit)];
            2'd1: r_sclo <= 1'b1;
            2'd2: if (r_bit == 4'd8) r_ack_ok <= ~bus.SDAI;
            default: begin
              r_sclo <= 1'b0;
              if (r_bit == 4'd8) begin
                r_bit   <= 4'd0;
                r_state <= (r_ack_ok && (r_nbytes != 3'd0)) ? S_RDBYTE : S_STOP;
              end else begin
                r_bit <= r_bit + 4'd1;
              end
            end
          endcase
        end

        // Eight data bits from the slave, then our ACK (NACK on the final byte).
        S_RDBYTE: begin
          r_ph <= r_ph + 2'd1;
          unique case (r_ph)
            2'd0: r_sdao <= (r_bit == 4'd8) ? w_last : 1'b1;
            2'd1: r_sclo <= 1'b1;
            2'd2: if (r_bit < 4'd8) r_shift <= {r_shift[6:0], bus.SDAI};
            default: begin
              r_sclo <= 1'b0;
              if (r_bit == 4'd7) begin
                for (int unsigned k = 0; k < MAX_BYTES; k++) begin
                  if (r_byte == 3'(k)) r_data[8*(MAX_BYTES-k)-1 -: 8] <= r_shift;
                end
                if (w_last) r_complete <= 1'b1;
              end
              if (r_bit == 4'd8) begin
                r_bit  <= 4'd0;
                r_byte <= r_byte + 3'd1;
                if (w_last) r_state <= S_STOP;
              end else begin
                r_bit <= r_bit + 4'd1;
              end
            end
          endcase
        end

        // SDA low with SCL low, SCL released, then SDA released; a NACKed address may retry.
        S_STOP: begin
          r_ph <= r_ph + 2'd1;
          if (r_ph == 2'd0) begin
            r_sdao <= 1'b0;
            r_sclo <= 1'b0;
          end else if (r_ph == 2'd1) begin
            r_sclo <= 1'b1;
          end else if (r_ph == 2'd2) begin
            r_sdao <= 1'b1;
            r_ph   <= 2'd0;
            if (!r_ack_ok && (r_attempt != LAST_ATTEMPT)) begin
              r_attempt <= r_attempt + AW'(1);
              r_state   <= S_START;
            end else begin
              r_end_ok <= 1'b1;
              r_dv     <= r_complete;
              r_state  <= S_DONE;
            end
          end
        end

        // Hold here until GO drops so a held GO never restarts the bus.
        S_DONE: begin
          r_sdao   <= 1'b1;
          r_sclo   <= 1'b1;
          r_end_ok <= 1'b1;
          if (!bus.GO) r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.SDAO       = r_sdao;
  assign bus.SCLO       = r_sclo;
  assign bus.END_OK     = r_end_ok;
  assign bus.ACK_OK     = r_ack_ok;
  assign bus.DATA       = r_data;
  assign bus.DATA_VALID = r_dv;
  assign bus.ST         = 8'(r_state);
  assign bus.CNT        = 8'(r_bit);
  assign bus.BYTE       = 8'(r_byte);
endmodule

// File: tb/tb_i2c_read_nbytes_c.sv
// Bench for i2c_read_nbytes_c: a behavioural I2C slave on the wired-AND SDA line plus a
// transaction-level model of the expected DATA, ACK_OK, timing and bus traffic.
module tb_i2c_read_nbytes_c;
  localparam int unsigned MAXB = 2;
  localparam int unsigned RMAX = 8;
  localparam int unsigned DW   = 8 * MAXB;

  logic PT_CK = 1'b0;
  logic RESET_N;
  always #5 PT_CK = ~PT_CK;

  i2c_read_nbytes_c_if #(.MAX_BYTES(MAXB)) bus ();
  i2c_read_nbytes_c #(.MAX_BYTES(MAXB), .RETRY_MAX(RMAX)) dut (
    .PT_CK  (PT_CK),
    .RESET_N(RESET_N),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  // Slave configuration, written only by the test tasks
  logic [7:0] cfg_tx [0:7];
  int         cfg_ntx   = 0;
  int         cfg_nacks = 0;
  int         cfg_gen   = 0;

  // Slave-side observations, written only by the slave process
  logic       slv_sda = 1'b1;
  int         start_cnt = 0;
  int         dv_cnt    = 0;
  logic [7:0] addr_q [$];
  logic       mack_q [$];

  logic line_sda;
  assign line_sda = bus.SDAO & slv_sda;
  assign bus.SDAI = line_sda;

  typedef enum int {M_IDLE, M_ADDR, M_READ} smode_t;

  // Behavioural slave: decodes START/STOP/bits from the line levels each tick
  always @(negedge PT_CK) begin
    static smode_t mode = M_IDLE;
    static int k = 0, seen_gen = -1, nacks_done = 0, tx_idx = 0;
    static logic prev_scl = 1'b1, prev_sda = 1'b1, addr_ack = 1'b0, last_mack = 1'b1;
    static logic [7:0] rx = 8'd0;
    logic scl, sda;
    if (bus.DATA_VALID === 1'b1) dv_cnt++;
    if (!RESET_N) begin
      mode = M_IDLE; k = 0; slv_sda = 1'b1; prev_scl = 1'b1; prev_sda = 1'b1;
    end else begin
      scl = bus.SCLO;
      sda = line_sda;
      if (prev_scl && scl && prev_sda && !sda) begin
        start_cnt++;
        mode = M_ADDR; k = 0; rx = 8'd0;
        if (seen_gen != cfg_gen) begin
          seen_gen = cfg_gen; nacks_done = 0; tx_idx = 0;
        end
      end else if (prev_scl && scl && !prev_sda && sda) begin
        mode = M_IDLE;
      end else if (!prev_scl && scl) begin
        if (mode != M_IDLE) begin
          k++;
          if (mode == M_ADDR && k <= 8) rx = {rx[6:0], sda};
          if (mode == M_READ && k == 9) begin
            last_mack = sda;
            mack_q.push_back(sda);
          end
        end
      end else if (prev_scl && !scl) begin
        if (mode == M_ADDR) begin
          if (k == 8) begin
            addr_q.push_back(rx);
            addr_ack = (nacks_done >= cfg_nacks);
            if (!addr_ack) nacks_done++;
            slv_sda = ~addr_ack;
          end else if (k == 9) begin
            slv_sda = 1'b1;
            if (addr_ack && tx_idx < cfg_ntx) begin
              mode = M_READ; k = 0; slv_sda = cfg_tx[tx_idx][7];
            end else begin
              mode = M_IDLE;
            end
          end
        end else if (mode == M_READ) begin
          if (k >= 1 && k < 8) slv_sda = cfg_tx[tx_idx][7-k];
          else if (k == 8) slv_sda = 1'b1;
          else if (k == 9) begin
            if (!last_mack && tx_idx + 1 < cfg_ntx) begin
              tx_idx++; k = 0; slv_sda = cfg_tx[tx_idx][7];
            end else begin
              mode = M_IDLE; slv_sda = 1'b1;
            end
          end
        end
      end
      prev_scl = scl;
      prev_sda = sda;
    end
  end

  // Transaction-level reference state
  logic [DW-1:0] model_data = '0;

  task automatic run_txn(input logic [7:0] addr, input logic [2:0] nb, input int nacks,
                         input bit hold_go, input string tag);
    int n, attempts, exp_lat, lat, s0, a0, m0, dv0;
    bit acked;
    logic [DW-1:0] exp_data;
    n = (int'(nb) > MAXB) ? MAXB : int'(nb);
`ifdef I2C_RD_ACK_RETRY_EN
    acked    = (nacks < RMAX);
    attempts = acked ? nacks + 1 : RMAX;
`else
    acked    = (nacks == 0);
    attempts = 1;
`endif
    exp_lat  = 42 * attempts + (acked ? 36 * n : 0);
    exp_data = model_data;
    if (acked)
      for (int k = 0; k < n; k++) exp_data[8*(MAXB-k)-1 -: 8] = cfg_tx[k];

    cfg_ntx = n; cfg_nacks = nacks; cfg_gen++;
    s0 = start_cnt; a0 = addr_q.size(); m0 = mack_q.size(); dv0 = dv_cnt;

    @(negedge PT_CK);
    bus.SLAVE_ADDRESS = addr; bus.NBYTES = nb; bus.GO = 1'b1;
    @(posedge PT_CK); #1;
    checks++;
    if (bus.END_OK !== 1'b0) begin
      errors++; $display("FAIL %s end_ok_fall got %b exp 0", tag, bus.END_OK);
    end
    lat = 0;
    while (bus.END_OK !== 1'b1 && lat < 2000) begin
      @(posedge PT_CK); #1;
      lat++;
      if (lat == 5) begin
        bus.SLAVE_ADDRESS = 8'($urandom); bus.NBYTES = 3'($urandom);
      end
    end
    checks++;
    if (lat != exp_lat) begin
      errors++; $display("FAIL %s latency got %0d exp %0d", tag, lat, exp_lat);
    end
    checks++;
    if (bus.DATA_VALID !== (acked && n > 0)) begin
      errors++; $display("FAIL %s data_valid_at_end got %b exp %b", tag, bus.DATA_VALID, acked && n > 0);
    end

    if (hold_go) begin
      repeat (60) @(posedge PT_CK);
      #1;
      checks++;
      if (start_cnt != s0 + attempts || bus.END_OK !== 1'b1) begin
        errors++; $display("FAIL %s go_held starts got %0d exp %0d end_ok %b", tag, start_cnt - s0, attempts, bus.END_OK);
      end
    end
    @(negedge PT_CK); bus.GO = 1'b0;
    repeat (3) @(posedge PT_CK);
    #1;

    checks++;
    if (bus.DATA !== exp_data) begin
      errors++; $display("FAIL %s data got %h exp %h", tag, bus.DATA, exp_data);
    end
    checks++;
    if (bus.ACK_OK !== acked) begin
      errors++; $display("FAIL %s ack_ok got %b exp %b", tag, bus.ACK_OK, acked);
    end
    checks++;
    if (start_cnt - s0 != attempts) begin
      errors++; $display("FAIL %s starts got %0d exp %0d", tag, start_cnt - s0, attempts);
    end
    checks++;
    if (dv_cnt - dv0 != ((acked && n > 0) ? 1 : 0)) begin
      errors++; $display("FAIL %s dv_pulses got %0d exp %0d", tag, dv_cnt - dv0, (acked && n > 0) ? 1 : 0);
    end
    checks++;
    if (addr_q.size() - a0 != attempts) begin
      errors++; $display("FAIL %s addr_frames got %0d exp %0d", tag, addr_q.size() - a0, attempts);
    end else begin
      for (int k = a0; k < addr_q.size(); k++) begin
        checks++;
        if (addr_q[k] !== {addr[7:1], 1'b1}) begin
          errors++; $display("FAIL %s addr_byte got %h exp %h", tag, addr_q[k], {addr[7:1], 1'b1});
        end
      end
    end
    checks++;
    if (mack_q.size() - m0 != (acked ? n : 0)) begin
      errors++; $display("FAIL %s master_acks got %0d exp %0d", tag, mack_q.size() - m0, acked ? n : 0);
    end else if (acked) begin
      for (int k = 0; k < n; k++) begin
        checks++;
        if (mack_q[m0+k] !== (k == n - 1)) begin
          errors++; $display("FAIL %s master_ack%0d got %b exp %b", tag, k, mack_q[m0+k], k == n - 1);
        end
      end
    end
    model_data = exp_data;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; bus.GO = 1'b0; bus.SLAVE_ADDRESS = 8'd0; bus.NBYTES = 3'd0;
    repeat (3) @(posedge PT_CK);
    #1;
    checks++;
    if ({bus.SDAO, bus.SCLO, bus.END_OK, bus.ACK_OK, bus.DATA_VALID} !== 5'b11100) begin
      errors++; $display("FAIL reset_lines got %b exp 11100", {bus.SDAO, bus.SCLO, bus.END_OK, bus.ACK_OK, bus.DATA_VALID});
    end
    checks++;
    if (bus.DATA !== '0 || bus.ST !== 8'd0 || bus.CNT !== 8'd0 || bus.BYTE !== 8'd0) begin
      errors++; $display("FAIL reset_regs got data %h st %0d cnt %0d byte %0d exp 0", bus.DATA, bus.ST, bus.CNT, bus.BYTE);
    end
    @(negedge PT_CK); RESET_N = 1'b1;
    repeat (2) @(posedge PT_CK);
  endtask

  task automatic test_two_byte();
    cfg_tx[0] = 8'hA5; cfg_tx[1] = 8'h3C;
    run_txn(8'h6C, 3'd2, 0, 1'b0, "two_byte");
    checks++;
    if (bus.DATA !== 16'hA53C) begin
      errors++; $display("FAIL two_byte_literal got %h exp a53c", bus.DATA);
    end
  endtask

  task automatic test_addr_nack();
    cfg_tx[0] = 8'h11; cfg_tx[1] = 8'h22;
`ifdef I2C_RD_ACK_RETRY_EN
    run_txn(8'h50, 3'd2, RMAX, 1'b0, "addr_nack_all");
`else
    run_txn(8'h50, 3'd2, 1, 1'b0, "addr_nack");
`endif
  endtask

  task automatic test_retry();
`ifdef I2C_RD_ACK_RETRY_EN
    cfg_tx[0] = 8'h5A;
    run_txn(8'h90, 3'd1, 3, 1'b0, "retry3");
    checks++;
    if (bus.DATA[15:8] !== 8'h5A) begin
      errors++; $display("FAIL retry_byte got %h exp 5a", bus.DATA[15:8]);
    end
`endif
  endtask

  task automatic test_nbytes_bounds();
    run_txn(8'h3E, 3'd0, 0, 1'b0, "nbytes0");
    cfg_tx[0] = 8'hC3; cfg_tx[1] = 8'h7E;
    run_txn(8'h3E, 3'd7, 0, 1'b0, "nbytes7");
  endtask

  task automatic test_go_held();
    cfg_tx[0] = 8'h0F; cfg_tx[1] = 8'hF0;
    run_txn(8'h22, 3'd1, 0, 1'b1, "go_held");
    cfg_tx[0] = 8'h96;
    run_txn(8'h22, 3'd2, 0, 1'b0, "after_go_held");
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      int nacks;
      for (int k = 0; k < 8; k++) cfg_tx[k] = 8'($urandom);
`ifdef I2C_RD_ACK_RETRY_EN
      nacks = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, RMAX + 1)) : 0;
`else
      nacks = ($urandom_range(0, 3) == 0) ? 1 : 0;
`endif
      run_txn(8'($urandom), 3'($urandom_range(0, 7)), nacks, 1'b0, $sformatf("rand%0d", i));
    end
  endtask

  task automatic test_reset_mid();
    cfg_tx[0] = 8'hE7; cfg_tx[1] = 8'h18;
    cfg_ntx = 2; cfg_nacks = 0; cfg_gen++;
    @(negedge PT_CK);
    bus.SLAVE_ADDRESS = 8'h44; bus.NBYTES = 3'd2; bus.GO = 1'b1;
    @(posedge PT_CK);
    // advance to SCL-high of the fourth bit of the first data byte
    repeat (53) @(posedge PT_CK);
    #1;
    RESET_N = 1'b0;
    #1;
    checks++;
    if ({bus.SDAO, bus.SCLO, bus.END_OK} !== 3'b111) begin
      errors++; $display("FAIL reset_mid_lines got %b exp 111", {bus.SDAO, bus.SCLO, bus.END_OK});
    end
    checks++;
    if (bus.DATA !== '0) begin
      errors++; $display("FAIL reset_mid_data got %h exp 0", bus.DATA);
    end
    model_data = '0;
    bus.GO = 1'b0;
    repeat (3) @(posedge PT_CK);
    @(negedge PT_CK); RESET_N = 1'b1;
    repeat (3) @(posedge PT_CK);
    cfg_tx[0] = 8'h81;
    run_txn(8'h44, 3'd1, 0, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_two_byte();
    test_addr_nack();
    test_retry();
    test_nbytes_bounds();
    test_go_held();
    test_random();
    test_two_byte();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
